boss_ctrl: RTL and testbench

- Sequential controller that produces the boss sprite position and animation frame (boss_x, boss_y, boss_state) consumed by the boss drawing block.
- Runs the boss behaviour FSM during STAGE3: chase the player, attack when close, stun on hit, die at zero HP.
- Coordinates are in the 320x240 half-resolution playfield, top-left of a 10x10 sprite.

---
 rtl/boss_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_boss_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boss_ctrl.sv
// boss_ctrl: boss behaviour controller for the boss stage.
// Chases the player, attacks when close, is stunned when hit and dies at zero HP.
// Produces the registered sprite position and animation frame for the boss drawing block.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   state      global game state; the boss only runs while state == STAGE3
//   player_x   player sprite x (320x240 half-resolution playfield)
//   player_y   player sprite y
//   hit        one-cycle pulse, boss struck by the player
//   boss_x     boss sprite x (top-left of 10x10 sprite), registered
//   boss_y     boss sprite y, registered
//   boss_state animation frame index 0..15, registered
//   boss_hp    remaining hit points, registered
//   boss_dead  high while in DEAD, registered
//   attack     one-cycle pulse on entry to ATTACK, registered
module boss_ctrl #(
  parameter int unsigned MOVE_DIV   = 2000000,
  parameter int unsigned ANIM_DIV   = 5000000,
  parameter int unsigned HP_INIT    = 8,
  parameter int unsigned START_X    = 155,
  parameter int unsigned START_Y    = 40,
  parameter int unsigned ATK_RANGE  = 20,
  parameter int unsigned ATK_TICKS  = 8,
  parameter int unsigned STUN_TICKS = 16,
  parameter int unsigned STAGE3     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       hit,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic [3:0] boss_hp,
  output logic       boss_dead,
  output logic       attack
);

  localparam logic [2:0] StInactive = 3'd0;
  localparam logic [2:0] StChase    = 3'd1;
  localparam logic [2:0] StAttack   = 3'd2;
  localparam logic [2:0] StHurt     = 3'd3;
  localparam logic [2:0] StDead     = 3'd4;

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned PMAX = (ATK_TICKS > STUN_TICKS) ? ATK_TICKS : STUN_TICKS;
  localparam int PW = $clog2(PMAX + 1);

  localparam logic [MW-1:0] MoveLast  = MW'(MOVE_DIV - 1);
  localparam logic [AW-1:0] AnimLast  = AW'(ANIM_DIV - 1);
  localparam logic [PW-1:0] AtkLast   = PW'(ATK_TICKS - 1);
  localparam logic [PW-1:0] StunLast  = PW'(STUN_TICKS - 1);
  localparam logic [8:0]    XMax      = 9'd310;
  localparam logic [8:0]    YMax      = 9'd230;
  localparam logic [8:0]    Range     = 9'(ATK_RANGE);
  localparam logic [8:0]    StartX    = 9'(START_X);
  localparam logic [8:0]    StartY    = 9'(START_Y);
  localparam logic [3:0]    HpInit    = 4'(HP_INIT);
  localparam logic [3:0]    StageBoss = 4'(STAGE3);

  logic [MW-1:0] move_cnt_q;
  logic [AW-1:0] anim_cnt_q;
  logic          move_tick, anim_tick;

  logic [2:0]    fsm_q, fsm_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    frame_q, frame_d;
  logic [3:0]    hp_q, hp_d;
  logic          dead_q, dead_d;
  logic          attack_q, attack_d;

  logic [8:0]    dx, dy, step_x, step_y;
  logic          in_range, in_stage;

  assign move_tick = (move_cnt_q == MoveLast);
  assign anim_tick = (anim_cnt_q == AnimLast);

  // Free-running tick dividers; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst || move_tick) move_cnt_q <= '0;
    else                  move_cnt_q <= move_cnt_q + MW'(1);
    if (rst || anim_tick) anim_cnt_q <= '0;
    else                  anim_cnt_q <= anim_cnt_q + AW'(1);
  end

  assign in_stage = (state == StageBoss);
  assign dx       = (player_x >= x_q) ? (player_x - x_q) : (x_q - player_x);
  assign dy       = (player_y >= y_q) ? (player_y - y_q) : (y_q - player_y);
  assign in_range = (dx < Range) && (dy < Range);

  // One step toward the player per axis, never past the playfield clamp.
  always_comb begin
    step_x = x_q;
    if (player_x > x_q && x_q < XMax)      step_x = x_q + 9'd1;
    else if (player_x < x_q && x_q != '0)  step_x = x_q - 9'd1;
    step_y = y_q;
    if (player_y > y_q && y_q < YMax)      step_y = y_q + 9'd1;
    else if (player_y < y_q && y_q != '0)  step_y = y_q - 9'd1;
  end

  always_comb begin
    fsm_d    = fsm_q;
    phase_d  = phase_q;
    x_d      = x_q;
    y_d      = y_q;
    hp_d     = hp_q;
    attack_d = 1'b0;

    if (!in_stage) begin
      fsm_d = StInactive;
      x_d   = StartX;
      y_d   = StartY;
      hp_d  = HpInit;
    end else begin
      case (fsm_q)
        StInactive: fsm_d = StChase;
        StChase: begin
          // A hit outranks the range check; no attack pulse on that cycle.
          if (hit) begin
            hp_d  = hp_q - 4'd1;
            fsm_d = (hp_q == 4'd1) ? StDead : StHurt;
          end else if (in_range) begin
            fsm_d    = StAttack;
            attack_d = 1'b1;
          end else if (move_tick) begin
            x_d = step_x;
            y_d = step_y;
          end
        end
        StAttack: begin
          if (hit) begin
            hp_d  = hp_q - 4'd1;
            fsm_d = (hp_q == 4'd1) ? StDead : StHurt;
          end else if (move_tick) begin
            if (phase_q == AtkLast) fsm_d = StChase;
            else                    phase_d = phase_q + PW'(1);
          end
        end
        StHurt: begin
          if (move_tick) begin
            if (phase_q == StunLast) fsm_d = StChase;
            else                     phase_d = phase_q + PW'(1);
          end
        end
        StDead:  fsm_d = StDead;
        default: fsm_d = StInactive;
      endcase
    end

    if (fsm_d != fsm_q) phase_d = '0;
  end

  // Animation index: reset on any state change (wins over anim_tick).
  always_comb begin
    idx_d = idx_q;
    if (!in_stage || fsm_d != fsm_q) idx_d = 2'd0;
    else if (anim_tick)              idx_d = (fsm_q == StHurt) ? {1'b0, ~idx_q[0]} : idx_q + 2'd1;

    case (fsm_d)
      StChase:  frame_d = {2'b01, idx_d};
      StAttack: frame_d = {2'b10, idx_d};
      StHurt:   frame_d = {2'b11, idx_d};
      StDead:   frame_d = 4'd15;
      default:  frame_d = {2'b00, idx_d};
    endcase
    dead_d = (fsm_d == StDead);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= StInactive;
      phase_q  <= '0;
      idx_q    <= 2'd0;
      x_q      <= StartX;
      y_q      <= StartY;
      frame_q  <= 4'd0;
      hp_q     <= HpInit;
      dead_q   <= 1'b0;
      attack_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      hp_q     <= hp_d;
      dead_q   <= dead_d;
      attack_q <= attack_d;
    end
  end

  assign boss_x     = x_q;
  assign boss_y     = y_q;
  assign boss_state = frame_q;
  assign boss_hp    = hp_q;
  assign boss_dead  = dead_q;
  assign attack     = attack_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// Testbench for boss_ctrl: fixed vector table, directed corner sequences and
// randomized stimulus checked every cycle against a behavioural model.
module tb_boss_ctrl;

  localparam int MOVE_DIV   = 4;
  localparam int ANIM_DIV   = 8;
  localparam int HP_INIT    = 2;
  localparam int ATK_TICKS  = 2;
  localparam int STUN_TICKS = 3;
  localparam int START_X    = 155;
  localparam int START_Y    = 40;
  localparam int ATK_RANGE  = 20;
  localparam int STAGE3     = 6;
  localparam int X_MAX      = 310;
  localparam int Y_MAX      = 230;

  // Model modes; frame base is 4 * mode for the first four.
  localparam int M_INACT  = 0;
  localparam int M_CHASE  = 1;
  localparam int M_ATTACK = 2;
  localparam int M_HURT   = 3;
  localparam int M_DEAD   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state = 4'd0;
  logic [8:0] player_x = 9'd0;
  logic [8:0] player_y = 9'd0;
  logic       hit = 1'b0;
  logic [8:0] boss_x, boss_y;
  logic [3:0] boss_state, boss_hp;
  logic       boss_dead, attack;

  boss_ctrl #(
    .MOVE_DIV  (MOVE_DIV),
    .ANIM_DIV  (ANIM_DIV),
    .HP_INIT   (HP_INIT),
    .ATK_TICKS (ATK_TICKS),
    .STUN_TICKS(STUN_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .player_x  (player_x),
    .player_y  (player_y),
    .hit       (hit),
    .boss_x    (boss_x),
    .boss_y    (boss_y),
    .boss_state(boss_state),
    .boss_hp   (boss_hp),
    .boss_dead (boss_dead),
    .attack    (attack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_mode = M_INACT, m_x = START_X, m_y = START_Y, m_hp = HP_INIT;
  int m_idx = 0, m_ticks = 0, m_cyc = 0;
  bit m_att = 1'b0;

  typedef struct {
    bit         rst;
    int         st;
    int         px;
    int         py;
    bit         hit;
    int         n;
    int         ex;
    int         ey;
    int         ef;
    int         ehp;
    bit         ed;
    bit         ea;
  } vec_t;

  vec_t tbl [16];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int toward(input int cur, input int tgt, input int hi);
    if (tgt > cur && cur < hi) return cur + 1;
    if (tgt < cur && cur > 0)  return cur - 1;
    return cur;
  endfunction

  function automatic int pack(input int x, input int y, input int f, input int hp,
                              input bit d, input bit a);
    logic [27:0] v;
    v = {9'(x), 9'(y), 4'(f), 4'(hp), d, a};
    return int'(v);
  endfunction

  function automatic int dut_out();
    logic [27:0] v;
    v = {boss_x, boss_y, boss_state, boss_hp, boss_dead, attack};
    return int'(v);
  endfunction

  function automatic int model_out();
    int f;
    f = (m_mode == M_DEAD) ? 15 : 4 * m_mode + m_idx;
    return pack(m_x, m_y, f, m_hp, m_mode == M_DEAD, m_att);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit r, input int st, input int px, input int py, input bit h);
    int nmode, nx, ny, nhp, nidx, nticks;
    bit natt, mt, at;
    if (r) begin
      m_mode = M_INACT; m_x = START_X; m_y = START_Y; m_hp = HP_INIT;
      m_idx = 0; m_ticks = 0; m_att = 1'b0; m_cyc = 0;
      return;
    end
    mt = (m_cyc % MOVE_DIV) == MOVE_DIV - 1;
    at = (m_cyc % ANIM_DIV) == ANIM_DIV - 1;
    nmode = m_mode; nx = m_x; ny = m_y; nhp = m_hp; nticks = m_ticks; natt = 1'b0;
    if (st != STAGE3) begin
      nmode = M_INACT; nx = START_X; ny = START_Y; nhp = HP_INIT;
    end else if (m_mode == M_INACT) begin
      nmode = M_CHASE;
    end else if ((m_mode == M_CHASE || m_mode == M_ATTACK) && h) begin
      nhp   = m_hp - 1;
      nmode = (nhp == 0) ? M_DEAD : M_HURT;
    end else if (m_mode == M_CHASE) begin
      if (iabs(px - m_x) < ATK_RANGE && iabs(py - m_y) < ATK_RANGE) begin
        nmode = M_ATTACK;
        natt  = 1'b1;
      end else if (mt) begin
        nx = toward(m_x, px, X_MAX);
        ny = toward(m_y, py, Y_MAX);
      end
    end else if ((m_mode == M_ATTACK || m_mode == M_HURT) && mt) begin
      nticks = m_ticks + 1;
      if (nticks == ((m_mode == M_ATTACK) ? ATK_TICKS : STUN_TICKS)) nmode = M_CHASE;
    end
    if (nmode != m_mode || st != STAGE3) begin
      nidx = 0;
      nticks = 0;
    end else if (at) begin
      nidx = (m_idx + 1) % ((m_mode == M_HURT) ? 2 : 4);
    end else begin
      nidx = m_idx;
    end
    m_mode = nmode; m_x = nx; m_y = ny; m_hp = nhp; m_idx = nidx; m_ticks = nticks;
    m_att = natt;
    m_cyc++;
  endtask

  // Drive one cycle, predict it, then compare after the edge.
  task automatic apply(input bit r, input int st, input int px, input int py, input bit h);
    rst = r; state = 4'(st); player_x = 9'(px); player_y = 9'(py); hit = h;
    model_edge(r, st, px, py, h);
    @(posedge clk);
    #1;
    check("model", dut_out(), model_out());
  endtask

  initial begin
    int max_x, max_y, px, py;
    bit r, h;
    int st;

    //           rst st  px   py   hit n  x    y   f   hp d  a
    tbl[0]  = '{1, 0, 155, 200, 0, 1, 155, 40, 0,  2, 0, 0};
    tbl[1]  = '{0, 6, 155, 200, 0, 1, 155, 40, 4,  2, 0, 0};
    tbl[2]  = '{0, 6, 155, 200, 0, 3, 155, 41, 4,  2, 0, 0};
    tbl[3]  = '{0, 6, 155, 200, 0, 4, 155, 42, 5,  2, 0, 0};
    tbl[4]  = '{0, 6, 155, 200, 0, 8, 155, 44, 6,  2, 0, 0};
    tbl[5]  = '{0, 6, 155, 200, 0, 8, 155, 46, 7,  2, 0, 0};
    tbl[6]  = '{0, 6, 155, 200, 0, 8, 155, 48, 4,  2, 0, 0};
    tbl[7]  = '{0, 8, 155, 200, 0, 1, 155, 40, 0,  2, 0, 0};
    tbl[8]  = '{0, 6, 155, 200, 0, 1, 155, 40, 4,  2, 0, 0};
    tbl[9]  = '{0, 6, 155, 200, 1, 1, 155, 40, 12, 1, 0, 0};
    tbl[10] = '{0, 6, 155, 200, 1, 1, 155, 40, 12, 1, 0, 0};
    tbl[11] = '{0, 6, 155, 200, 0, 4, 155, 40, 13, 1, 0, 0};
    tbl[12] = '{0, 6, 155, 200, 0, 4, 155, 40, 4,  1, 0, 0};
    tbl[13] = '{0, 6, 155, 200, 0, 4, 155, 41, 5,  1, 0, 0};
    tbl[14] = '{0, 6, 155, 200, 1, 1, 155, 41, 15, 0, 1, 0};
    tbl[15] = '{0, 6, 155, 200, 0, 8, 155, 41, 15, 0, 1, 0};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        apply(tbl[i].rst, tbl[i].st, tbl[i].px, tbl[i].py, tbl[i].hit);
      check($sformatf("row%0d", i), dut_out(),
            pack(tbl[i].ex, tbl[i].ey, tbl[i].ef, tbl[i].ehp, tbl[i].ed, tbl[i].ea));
    end

    // Chase to (300,50): attack fires once the boss reaches x=281.
    apply(1, 0, 300, 50, 0);
    for (int i = 0; i < 2000 && attack !== 1'b1; i++) apply(0, 6, 300, 50, 0);
    check("atk_pulse", int'(attack), 1);
    check("atk_x", int'(boss_x), 281);
    check("atk_y", int'(boss_y), 50);
    check("atk_frame", int'(boss_state), 8);
    apply(0, 6, 300, 50, 0);
    check("atk_one_cycle", int'(attack), 0);
    for (int i = 0; i < 40 && boss_state != 4'd4; i++) apply(0, 6, 300, 50, 0);
    check("atk_return", int'(boss_state), 4);

    // Still in range, so a hit now competes with a new attack; hit wins.
    apply(0, 6, 300, 50, 1);
    check("hit_vs_range_frame", int'(boss_state), 12);
    check("hit_vs_range_attack", int'(attack), 0);
    check("hit_vs_range_hp", int'(boss_hp), HP_INIT - 1);

    // After the stun the boss re-attacks; leave the stage mid-ATTACK.
    for (int i = 0; i < 60 && attack !== 1'b1; i++) apply(0, 6, 300, 50, 0);
    check("reattack", int'(attack), 1);
    apply(0, 8, 300, 50, 0);
    check("exit_reinit", dut_out(), pack(START_X, START_Y, 0, HP_INIT, 0, 0));
    apply(0, 6, 300, 50, 0);
    check("reenter_chase", int'(boss_state), 4);

    // Corner chase: x must saturate at 310 and never exceed the clamps.
    apply(1, 0, 319, 239, 0);
    max_x = 0;
    max_y = 0;
    for (int i = 0; i < 900; i++) begin
      apply(0, 6, 319, 239, 0);
      if (int'(boss_x) > max_x) max_x = int'(boss_x);
      if (int'(boss_y) > max_y) max_y = int'(boss_y);
    end
    check("x_clamp", int'(boss_x), X_MAX);
    check("x_max", max_x, X_MAX);
    check("y_max_ok", int'(max_y <= Y_MAX), 1);

    // Randomized run against the model.
    apply(1, 0, 0, 0, 0);
    px = 200;
    py = 100;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 15)) : STAGE3;
      h  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          px = int'($urandom_range(0, 319));
          py = int'($urandom_range(0, 239));
        end else begin
          px = m_x + int'($urandom_range(0, 50)) - 25;
          py = m_y + int'($urandom_range(0, 50)) - 25;
          if (px < 0) px = 0;
          if (py < 0) py = 0;
        end
      end
      apply(r, st, px, py, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
